instr_mem_array: RTL and testbench

- Small synchronous instruction store: DEPTH words of WIDTH bits, addressed by a 4-bit pointer.
- Separate write and read strobes; the read word is presented on a registered output.
- Sits between the instruction loader (writes program words) and the fetch stage (reads the word at the program pointer).

---
 rtl/instr_mem_array.sv | 169 ++++++++++++++++
 tb/tb_instr_mem_array.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_array.sv
// -----------------------------------------------------------------------------
// instr_mem_array
//
// Small synchronous instruction store placed between the instruction loader
// (which writes program words) and the fetch stage (which reads the word at
// the program pointer). DEPTH words of WIDTH bits, one shared word pointer,
// separate write and read strobes, and a registered read-data output.
//
// Ports (positional order):
//   data          output [WIDTH-1:0]  registered read data
//   pointer       input  [AW-1:0]     word address for both read and write
//   write_data    input               write strobe, active-high, level-sampled
//   read_data     input               read strobe, active-high, level-sampled
//   data_to_write input  [WIDTH-1:0]  write data, stored unmodified
//   reset         input               asynchronous active-low reset
//   clk           input               system clock, rising-edge
//   addr_err      output              (only with INSTR_MEM_ADDR_ERR_EN defined)
//                                     registered one-cycle flag for any sampled
//                                     access whose pointer is >= DEPTH
//
// Optional feature macro: INSTR_MEM_ADDR_ERR_EN
//
// Behaviour notes:
//   - reset low clears every word and the output register immediately and
//     keeps them cleared for as long as it stays low.
//   - Because both strobes share one pointer, a simultaneous read and write
//     always target the same word; the read returns the incoming write data
//     (write-first).
//   - Out-of-range writes modify nothing; out-of-range reads load data with 0.
//   - data holds its value on cycles without a read.
// -----------------------------------------------------------------------------
module instr_mem_array #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  output logic [WIDTH-1:0] data,
  input  logic [AW-1:0]    pointer,
  input  logic             write_data,
  input  logic             read_data,
  input  logic [WIDTH-1:0] data_to_write,
  input  logic             reset,
  input  logic             clk
`ifdef INSTR_MEM_ADDR_ERR_EN
  ,
  output logic             addr_err
`endif
);

  // One extra bit so that DEPTH == 2**AW is representable in the compare.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  // Storage and output register.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Decoded request qualifiers.
  logic             in_range_s;
  logic             wr_ok_s;
  logic             rd_ok_s;
  logic [WIDTH-1:0] rd_word_s;

  // True when the pointer addresses an implemented word.
  function automatic logic ptr_in_range(input logic [AW-1:0] ptr);
    ptr_in_range = ({1'b0, ptr} < DEPTH_W);
  endfunction

  // Qualify the strobes with the address range check.
  always_comb begin
    in_range_s = ptr_in_range(pointer);
    wr_ok_s    = write_data & in_range_s;
    rd_ok_s    = read_data & in_range_s;
  end

  // Next-state of the storage array: only the addressed word may change.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok_s && (pointer == AW'(i))) begin
        mem_d[i] = data_to_write;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Read multiplexer over the current contents. Decoding by compare rather
  // than direct indexing keeps pointers beyond DEPTH from selecting anything.
  always_comb begin
    rd_word_s = {WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (pointer == AW'(i)) begin
        rd_word_s = mem_q[i];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
  end

  // Output register next-state: write-first on a same-edge read and write,
  // zero for an out-of-range read, hold when no read is sampled.
  always_comb begin
    data_d = data_q;
    if (read_data) begin
      if (rd_ok_s) begin
        if (wr_ok_s) begin
          data_d = data_to_write;
        end else begin
          data_d = rd_word_s;
        end
      end else begin
        data_d = {WIDTH{1'b0}};
      end
    end else begin
      data_d = data_q;
    end
  end

  // Storage array registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read-data output register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

`ifdef INSTR_MEM_ADDR_ERR_EN
  logic addr_err_q;
  logic addr_err_d;

  // Flag any sampled access (read or write) to an unimplemented word.
  always_comb begin
    if ((read_data || write_data) && !in_range_s) begin
      addr_err_d = 1'b1;
    end else begin
      addr_err_d = 1'b0;
    end
  end

  // Address-error flag register; naturally pulses for a single cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= addr_err_d;
    end
  end

  assign addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_instr_mem_array.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_array
//
// Directed plus randomized bench for instr_mem_array. A behavioural model
// (plain array of words plus an expected output word) is updated from the
// access rules after every clock edge and compared against the DUT.
// -----------------------------------------------------------------------------
module tb_instr_mem_array;

  localparam int WIDTH = 26;
  localparam int DEPTH = 10;
  localparam int AW    = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] data;
  logic [AW-1:0]    pointer;
  logic             write_data;
  logic             read_data;
  logic [WIDTH-1:0] data_to_write;
`ifdef INSTR_MEM_ADDR_ERR_EN
  logic             addr_err;
`endif

  instr_mem_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .data          (data),
    .pointer       (pointer),
    .write_data    (write_data),
    .read_data     (read_data),
    .data_to_write (data_to_write),
    .reset         (reset),
    .clk           (clk)
`ifdef INSTR_MEM_ADDR_ERR_EN
    ,
    .addr_err      (addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] ref_data;
  logic             ref_err;

  int n_cmp;
  int n_bad;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_err(input string tag, input logic exp);
`ifdef INSTR_MEM_ADDR_ERR_EN
    n_cmp++;
    assert (addr_err === exp) else begin
      n_bad++;
      $error("FAIL %s: addr_err observed %b expected %b", tag, addr_err, exp);
    end
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_data = '0;
    ref_err  = 1'b0;
  endtask

  // One clock cycle: drive, clock, update the model, compare 1 time unit later.
  task automatic cycle(input string tag, input logic wr, input logic rd,
                       input int ptr, input logic [WIDTH-1:0] wdata);
    write_data    = wr;
    read_data     = rd;
    pointer       = AW'(ptr);
    data_to_write = wdata;
    @(posedge clk);
    if (wr && ptr < DEPTH) ref_mem[ptr] = wdata;
    if (rd) ref_data = (ptr < DEPTH) ? ref_mem[ptr] : '0;
    ref_err = (wr || rd) && (ptr >= DEPTH);
    #1;
    check(tag, data, ref_data);
    check_err(tag, ref_err);
  endtask

  logic [31:0]      wide;
  logic [WIDTH-1:0] rnd_w;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    write_data = 1'b0;
    read_data = 1'b0;
    pointer = '0;
    data_to_write = '0;
    model_clear();

    // Power-on reset.
    reset = 1'b0;
    #12;
    check("reset_data", data, '0);
    check_err("reset_err", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill with nonzero values, read one back, then async reset mid-cycle.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, i, WIDTH'(32'h100 + i));
    cycle("fill_rd", 1'b0, 1'b1, 7, '0);
    check("fill_rd_val", data, 26'h107);
    write_data = 1'b0;
    read_data  = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    model_clear();
    check("async_rst_data", data, '0);
    @(posedge clk);
    #1;
    check("rst_held", data, '0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) cycle("post_rst_rd", 1'b0, 1'b1, i, '0);

    // Write/read both checkerboard patterns at every address.
    for (int i = 0; i < DEPTH; i++) begin
      cycle("wr55", 1'b1, 1'b0, i, 26'h555555);
      cycle("rd55", 1'b0, 1'b1, i, '0);
      check("rd55_const", data, 26'h555555);
      cycle("wrAA", 1'b1, 1'b0, i, 26'hAAAAAA);
      cycle("rdAA", 1'b0, 1'b1, i, '0);
      check("rdAA_const", data, 26'hAAAAAA);
    end
    for (int i = 0; i < DEPTH; i++) cycle("rd_all", 1'b0, 1'b1, i, '0);

    // Walking byte at address 3, including truncation at the top.
    cycle("walk_w0", 1'b1, 1'b0, 3, 26'hAA);
    cycle("walk_r0", 1'b0, 1'b1, 3, '0);
    check("walk0", data, 26'hAA);
    cycle("walk_w1", 1'b1, 1'b0, 3, 26'hAA00);
    cycle("walk_r1", 1'b0, 1'b1, 3, '0);
    check("walk1", data, 26'hAA00);
    cycle("walk_w2", 1'b1, 1'b0, 3, 26'hAA0000);
    cycle("walk_r2", 1'b0, 1'b1, 3, '0);
    check("walk2", data, 26'hAA0000);
    wide = 32'hAA << 24;
    cycle("walk_w3", 1'b1, 1'b0, 3, wide[WIDTH-1:0]);
    cycle("walk_r3", 1'b0, 1'b1, 3, '0);
    check("walk3_trunc", data, 26'h2000000);
    cycle("walk_w4", 1'b1, 1'b0, 3, '0);
    cycle("walk_r4", 1'b0, 1'b1, 3, '0);
    check("walk4_zero", data, '0);

    // Write-first collision.
    cycle("coll_pre", 1'b1, 1'b0, 5, 26'h123456);
    cycle("coll", 1'b1, 1'b1, 5, 26'h3FFFFFF);
    check("coll_const", data, 26'h3FFFFFF);
    cycle("coll_after", 1'b0, 1'b1, 5, '0);

    // Hold across idle cycles (idle inputs deliberately noisy).
    cycle("hold_rd", 1'b0, 1'b1, 2, '0);
    check("hold_rd_const", data, 26'hAAAAAA);
    for (int k = 0; k < 5; k++) begin
      cycle("hold_idle", 1'b0, 1'b0, k, WIDTH'($urandom()));
      check("hold_const", data, 26'hAAAAAA);
    end

    // Out-of-range write and read.
    cycle("oor_wr", 1'b1, 1'b0, 12, 26'h111111);
    check("oor_wr_hold", data, 26'hAAAAAA);
    check_err("oor_wr_err", 1'b1);
    cycle("oor_gap", 1'b0, 1'b0, 0, '0);
    check_err("oor_wr_err_drop", 1'b0);
    cycle("oor_rd", 1'b0, 1'b1, 12, '0);
    check("oor_rd_zero", data, '0);
    check_err("oor_rd_err", 1'b1);
    cycle("oor_gap2", 1'b0, 1'b0, 0, '0);
    check_err("oor_rd_err_drop", 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle("oor_scan", 1'b0, 1'b1, i, '0);
    cycle("oor_max_wr", 1'b1, 1'b1, 15, 26'h3ABCDEF);
    cycle("oor_10_wr", 1'b1, 1'b0, 10, 26'h1234);
    for (int i = 0; i < DEPTH; i++) cycle("oor_scan2", 1'b0, 1'b1, i, '0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rnd_w = WIDTH'($urandom());
      cycle("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 15)), rnd_w);
    end
    for (int i = 0; i < DEPTH; i++) cycle("final_scan", 1'b0, 1'b1, i, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
